// File: rtl/ldm_stm_seq_pkg.sv
// Shared definitions for the block-transfer sequencer and the address stage.
// Holds the FSM encoding, the {P,U,W} bit positions and the per-beat byte step.
package ldm_stm_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int FUNC_W     = 3;
    localparam int FUNC_P_BIT = 2;
    localparam int FUNC_U_BIT = 1;
    localparam int FUNC_W_BIT = 0;

    localparam int STEP_BYTES = 4;

endpackage

// File: rtl/ldm_stm_seq_prio_enc.sv
// Priority encoder over the pending register list: returns the lowest set
// index when i_up=1 and the highest set index when i_up=0.
module prio_enc #(
    parameter int N  = 16,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_list,
    input  logic          i_up,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // Scan order chosen so the last matching assignment is the wanted end of the list.
    always_comb begin
        o_idx = '0;
        o_any = |i_list;
        if (i_up) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (i_list[i]) begin
                    o_idx = IW'(i);
                end else begin
                    o_idx = o_idx;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (i_list[i]) begin
                    o_idx = IW'(i);
                end else begin
                    o_idx = o_idx;
                end
            end
        end
    end

endmodule

// File: rtl/ldm_stm_seq.sv
// LDM/STM block-transfer sequencer: walks a register bitmap one beat at a time,
// stepping the running base and issuing a final base writeback.
module ldm_stm_seq
    import ldm_stm_seq_pkg::*;
#(
    parameter int  ADDR_W = 32,
    parameter int  NREG   = 16,
    localparam int IDX_W  = (NREG > 1) ? $clog2(NREG) : 1,
    localparam int CNT_W  = $clog2(NREG + 1)
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic                start_in,
    input  logic [NREG-1:0]     reg_list_in,
    input  logic [ADDR_W-1:0]   base_addr_in,
    input  logic [FUNC_W-1:0]   func_in,
    input  logic                load_in,
    input  logic                mem_ready_in,
    output logic                busy_out,
    output logic                ctrl_ldm_stm_start_S3_out,
    output logic [ADDR_W-1:0]   base_addr_out,
    output logic [FUNC_W-1:0]   func_out,
    output logic                load_out,
    output logic [IDX_W-1:0]    reg_idx_out,
    output logic                last_out,
    output logic                wb_en_out,
    output logic [ADDR_W-1:0]   wb_data_out,
    output logic                done_out
);

    state_t              r_state;
    logic                r_busy;
    logic [NREG-1:0]     r_pending;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_base_cap;
    logic [FUNC_W-1:0]   r_func;
    logic                r_load;
    logic [CNT_W-1:0]    r_popcnt;
    logic [IDX_W-1:0]    r_idx;
    logic                r_last;
    logic                r_valid;
    logic                r_wb_en;
    logic [ADDR_W-1:0]   r_wb_data;
    logic                r_done;

    state_t              w_state_nxt;
    logic [NREG-1:0]     w_pending_nxt;
    logic [ADDR_W-1:0]   w_base_nxt;
    logic [ADDR_W-1:0]   w_base_cap_nxt;
    logic [FUNC_W-1:0]   w_func_nxt;
    logic                w_load_nxt;
    logic [CNT_W-1:0]    w_popcnt_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic                w_last_nxt;
    logic                w_valid_nxt;
    logic                w_wb_en_nxt;
    logic [ADDR_W-1:0]   w_wb_data_nxt;
    logic                w_done_nxt;

    logic [CNT_W-1:0]    w_list_pop;
    logic [NREG-1:0]     w_pending_clr;
    logic [NREG-1:0]     w_enc_src;
    logic                w_enc_up;
    logic [IDX_W-1:0]    w_enc_idx;
    logic                w_enc_any;
    logic                w_enc_onehot;
    logic [ADDR_W-1:0]   w_base_step;
    logic [ADDR_W-1:0]   w_wb_val;
    logic [ADDR_W-1:0]   w_span;

    // Count of requested registers, taken once at capture.
    always_comb begin
        w_list_pop = '0;
        for (int i = 0; i < NREG; i++) begin
            w_list_pop = w_list_pop + CNT_W'(reg_list_in[i]);
        end
    end

    // The encoder sees the incoming list at capture, otherwise the list minus the beat in flight.
    assign w_pending_clr = r_pending & ~(NREG'(1) << r_idx);
    assign w_enc_src     = (r_state == ST_IDLE) ? reg_list_in : w_pending_clr;
    assign w_enc_up      = (r_state == ST_IDLE) ? func_in[FUNC_U_BIT] : r_func[FUNC_U_BIT];
    assign w_enc_onehot  = w_enc_any && ((w_enc_src & (w_enc_src - NREG'(1))) == '0);

    prio_enc #(
        .N  (NREG),
        .IW (IDX_W)
    ) u_prio_enc (
        .i_list (w_enc_src),
        .i_up   (w_enc_up),
        .o_idx  (w_enc_idx),
        .o_any  (w_enc_any)
    );

    assign w_base_step = r_func[FUNC_U_BIT] ? (r_base + ADDR_W'(STEP_BYTES))
                                            : (r_base - ADDR_W'(STEP_BYTES));
    assign w_span      = ADDR_W'(r_popcnt) * ADDR_W'(STEP_BYTES);
    assign w_wb_val    = r_func[FUNC_U_BIT] ? (r_base_cap + w_span) : (r_base_cap - w_span);

    // Next-state and next-output selection; mem_ready_in only feeds this path.
    always_comb begin
        w_state_nxt    = r_state;
        w_pending_nxt  = r_pending;
        w_base_nxt     = r_base;
        w_base_cap_nxt = r_base_cap;
        w_func_nxt     = r_func;
        w_load_nxt     = r_load;
        w_popcnt_nxt   = r_popcnt;
        w_idx_nxt      = r_idx;
        w_last_nxt     = r_last;
        w_valid_nxt    = r_valid;
        w_wb_en_nxt    = 1'b0;
        w_wb_data_nxt  = r_wb_data;
        w_done_nxt     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_in) begin
                    w_pending_nxt  = reg_list_in;
                    w_base_nxt     = base_addr_in;
                    w_base_cap_nxt = base_addr_in;
                    w_func_nxt     = func_in;
                    w_load_nxt     = load_in;
                    w_popcnt_nxt   = w_list_pop;
                    if (w_enc_any) begin
                        w_state_nxt = ST_XFER;
                        w_valid_nxt = 1'b1;
                        w_idx_nxt   = w_enc_idx;
                        w_last_nxt  = w_enc_onehot;
                    end else begin
                        w_state_nxt = ST_DONE;
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (mem_ready_in) begin
                    w_pending_nxt = w_pending_clr;
                    w_base_nxt    = w_base_step;
                    if (r_last) begin
                        w_state_nxt   = ST_DONE;
                        w_valid_nxt   = 1'b0;
                        w_last_nxt    = 1'b0;
                        w_done_nxt    = 1'b1;
                        w_wb_en_nxt   = r_func[FUNC_W_BIT];
                        w_wb_data_nxt = r_func[FUNC_W_BIT] ? w_wb_val : r_wb_data;
                    end else begin
                        w_idx_nxt  = w_enc_idx;
                        w_last_nxt = w_enc_onehot;
                    end
                end else begin
                    w_state_nxt = ST_XFER;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_valid_nxt   = 1'b0;
                w_last_nxt    = 1'b0;
                w_pending_nxt = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer without pulses.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_pending  <= '0;
            r_base     <= '0;
            r_base_cap <= '0;
            r_func     <= '0;
            r_load     <= 1'b0;
            r_popcnt   <= '0;
            r_idx      <= '0;
            r_last     <= 1'b0;
            r_valid    <= 1'b0;
            r_wb_en    <= 1'b0;
            r_wb_data  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_pending  <= w_pending_nxt;
            r_base     <= w_base_nxt;
            r_base_cap <= w_base_cap_nxt;
            r_func     <= w_func_nxt;
            r_load     <= w_load_nxt;
            r_popcnt   <= w_popcnt_nxt;
            r_idx      <= w_idx_nxt;
            r_last     <= w_last_nxt;
            r_valid    <= w_valid_nxt;
            r_wb_en    <= w_wb_en_nxt;
            r_wb_data  <= w_wb_data_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign busy_out                  = r_busy;
    assign ctrl_ldm_stm_start_S3_out = r_valid;
    assign base_addr_out             = r_base;
    assign func_out                  = r_func;
    assign load_out                  = r_load;
    assign reg_idx_out               = r_idx;
    assign last_out                  = r_last;
    assign wb_en_out                 = r_wb_en;
    assign wb_data_out               = r_wb_data;
    assign done_out                  = r_done;

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Self-checking bench for ldm_stm_seq: directed vector table, stall/reset
// sequences and randomized transfers against a list-based reference model.
module tb_ldm_stm_seq;

    localparam int AW = 32;
    localparam int NR = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [NR-1:0] reg_list;
    logic [AW-1:0] base_in;
    logic [2:0]    func_in;
    logic          load_in;
    logic          ready;
    logic          busy;
    logic          valid;
    logic [AW-1:0] base_out;
    logic [2:0]    func_out;
    logic          load_out;
    logic [IW-1:0] reg_idx;
    logic          last;
    logic          wb_en;
    logic [AW-1:0] wb_data;
    logic          done;

    int checks = 0;
    int errors = 0;

    int            q_idx[$];
    logic [AW-1:0] q_base[$];

    always #5 clk = ~clk;

    ldm_stm_seq #(.ADDR_W(AW), .NREG(NR)) dut (
        .clk_in                    (clk),
        .reset_in                  (reset),
        .start_in                  (start),
        .reg_list_in               (reg_list),
        .base_addr_in              (base_in),
        .func_in                   (func_in),
        .load_in                   (load_in),
        .mem_ready_in              (ready),
        .busy_out                  (busy),
        .ctrl_ldm_stm_start_S3_out (valid),
        .base_addr_out             (base_out),
        .func_out                  (func_out),
        .load_out                  (load_out),
        .reg_idx_out               (reg_idx),
        .last_out                  (last),
        .wb_en_out                 (wb_en),
        .wb_data_out               (wb_data),
        .done_out                  (done)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_valid"}, valid, 0);
        chk({nm, "_base"}, base_out, 0);
        chk({nm, "_func"}, func_out, 0);
        chk({nm, "_load"}, load_out, 0);
        chk({nm, "_idx"}, reg_idx, 0);
        chk({nm, "_last"}, last, 0);
        chk({nm, "_wb_en"}, wb_en, 0);
        chk({nm, "_wb_data"}, wb_data, 0);
        chk({nm, "_done"}, done, 0);
    endtask

    // Called just after a negedge with the DUT idle; returns just after a negedge, idle again.
    // mode 0: always ready, 1: random ready, 2: stall 2nd beat 3 cycles and poke start meanwhile.
    task automatic run_xfer(input logic [NR-1:0] list, input logic [AW-1:0] base,
                            input logic [2:0] func, input logic ld, input int mode,
                            output int n_acc, output int first_idx,
                            output logic wb_seen, output logic [AW-1:0] wb_val);
        int   stall;
        bit   done_seen;
        logic exp_wb_en;
        logic [AW-1:0] exp_wb;
        logic [AW-1:0] span;
        q_idx.delete();
        q_base.delete();
        if (func[1]) begin
            for (int i = 0; i < NR; i++) if (list[i]) q_idx.push_back(i);
        end else begin
            for (int i = NR - 1; i >= 0; i--) if (list[i]) q_idx.push_back(i);
        end
        for (int k = 0; k < q_idx.size(); k++)
            q_base.push_back(func[1] ? base + 32'(4 * k) : base - 32'(4 * k));
        span      = 32'(4 * q_idx.size());
        exp_wb_en = func[0] && (q_idx.size() != 0);
        exp_wb    = func[1] ? base + span : base - span;
        n_acc = 0; first_idx = -1; wb_seen = 1'b0; wb_val = '0; stall = 0; done_seen = 1'b0;

        chk("idle_before_start", busy, 0);
        start = 1'b1; reg_list = list; base_in = base; func_in = func; load_in = ld; ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
            start = 1'b0;
            if (q_idx.size() != 0) begin
                chk("beat_valid", valid, 1);
                chk("beat_busy", busy, 1);
                chk("beat_idx", reg_idx, q_idx[0]);
                chk("beat_base", base_out, q_base[0]);
                chk("beat_last", last, q_idx.size() == 1);
                chk("beat_func", func_out, func);
                chk("beat_load", load_out, ld);
                chk("beat_no_done", done, 0);
                chk("beat_no_wb", wb_en, 0);
                if (first_idx < 0) first_idx = int'(reg_idx);
                if (mode == 0) begin
                    ready = 1'b1;
                end else if (mode == 1) begin
                    ready = ($urandom_range(0, 3) != 0);
                end else if (n_acc == 1 && stall < 3) begin
                    ready = 1'b0;
                    if (stall == 0) begin
                        start = 1'b1; reg_list = 16'hFFFF; base_in = 32'hDEAD0000;
                        func_in = ~func; load_in = ~ld;
                    end
                    stall++;
                end else begin
                    ready = 1'b1;
                end
                if (ready) begin
                    void'(q_idx.pop_front());
                    void'(q_base.pop_front());
                    n_acc++;
                end
            end else begin
                ready = 1'b0;
                chk("done_valid_low", valid, 0);
                chk("done_pulse", done, 1);
                chk("done_busy", busy, 1);
                chk("done_wb_en", wb_en, exp_wb_en);
                if (exp_wb_en) chk("done_wb_data", wb_data, exp_wb);
                wb_seen = wb_en; wb_val = wb_data;
                done_seen = 1'b1;
            end
            @(negedge clk);
        end
        chk("done_within_budget", done_seen, 1);
        if (mode == 2 && n_acc >= 2) chk("stall_applied", stall, 3);
        chk("idle_after_busy", busy, 0);
        chk("idle_after_done", done, 0);
        chk("idle_after_wb", wb_en, 0);
    endtask

    typedef struct {
        logic [NR-1:0] list;
        logic [AW-1:0] base;
        logic [2:0]    func;
        logic          load;
        int            mode;
        int            exp_n;
        int            exp_first;
        logic          exp_wb_en;
        logic [AW-1:0] exp_wb;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int            n, first;
        logic          wbs;
        logic [AW-1:0] wbv;
        logic [NR-1:0] rl;
        logic [AW-1:0] rb;

        tbl[0] = '{16'h0013, 32'h00001000, 3'b111, 1'b1, 0, 3,  0, 1'b1, 32'h0000100C};
        tbl[1] = '{16'h8001, 32'h00002000, 3'b001, 1'b0, 0, 2, 15, 1'b1, 32'h00001FF8};
        tbl[2] = '{16'h0000, 32'h00003000, 3'b111, 1'b1, 0, 0,  0, 1'b0, 32'h00000000};
        tbl[3] = '{16'h0003, 32'hFFFFFFFC, 3'b011, 1'b0, 0, 2,  0, 1'b1, 32'h00000004};
        tbl[4] = '{16'h00F0, 32'h00004000, 3'b110, 1'b1, 2, 4,  4, 1'b0, 32'h00000000};
        tbl[5] = '{16'hFFFF, 32'h00000000, 3'b010, 1'b0, 1, 16, 0, 1'b0, 32'h00000000};
        tbl[6] = '{16'h0100, 32'h00000010, 3'b001, 1'b1, 1, 1,  8, 1'b1, 32'h0000000C};

        reset = 1'b1; start = 1'b0; reg_list = '0; base_in = '0; func_in = '0;
        load_in = 1'b0; ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset_state");
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_xfer(tbl[i].list, tbl[i].base, tbl[i].func, tbl[i].load, tbl[i].mode,
                     n, first, wbs, wbv);
            chk($sformatf("vec%0d_beats", i), n, tbl[i].exp_n);
            if (tbl[i].exp_n > 0) chk($sformatf("vec%0d_first", i), first, tbl[i].exp_first);
            chk($sformatf("vec%0d_wb_en", i), wbs, tbl[i].exp_wb_en);
            if (tbl[i].exp_wb_en) chk($sformatf("vec%0d_wb_data", i), wbv, tbl[i].exp_wb);
        end

        // Reset in the middle of a transfer.
        start = 1'b1; reg_list = 16'hFFFF; base_in = 32'h00000100; func_in = 3'b011; load_in = 1'b1;
        @(negedge clk);
        start = 1'b0; ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        #2 reset = 1'b1;
        #1 chk_all_zero("async_reset");
        @(negedge clk);
        chk_all_zero("held_reset");
        reset = 1'b0; ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_reset_no_done", done, 0);
            chk("post_reset_no_wb", wb_en, 0);
            chk("post_reset_idle", busy, 0);
        end
        run_xfer(16'h0005, 32'h00005000, 3'b011, 1'b0, 0, n, first, wbs, wbv);
        chk("after_reset_beats", n, 2);
        chk("after_reset_wb", wbv, 32'h00005008);

        for (int r = 0; r < 30; r++) begin
            rl = 16'($urandom);
            if ($urandom_range(0, 4) == 0) rl = '0;
            rb = $urandom;
            rb[1:0] = 2'b00;
            run_xfer(rl, rb, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 1), n, first, wbs, wbv);
            chk("rand_beats", n, $countones(rl));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ldm_stm_seq.md
LDM_STM_SEQ -- requirements
Module: ldm_stm_seq

Interface
REQ-001 Parameter ADDR_W, default 32, address and data width.
REQ-002 Parameter NREG, default 16, register-list width; register index width is log2(NREG).
REQ-003 clk_in  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_in  input  1  reset, asynchronous, active-high.
REQ-005 start_in  input  1  one-cycle request to begin a block transfer; sampled only in IDLE.
REQ-006 reg_list_in  input  NREG  register bitmap (bit i set = register i is transferred); captured with start_in.
REQ-007 base_addr_in  input  ADDR_W  base register value; captured with start_in.
REQ-008 func_in  input  3  {P,U,W}: bit2 pre-index, bit1 up, bit0 writeback; captured with start_in.
REQ-009 load_in  input  1  1 = LDM, 0 = STM; captured with start_in.
REQ-010 mem_ready_in  input  1  memory accepts the current beat this cycle.
REQ-011 busy_out  output  1  high whenever the state is not IDLE.
REQ-012 ctrl_ldm_stm_start_S3_out  output  1  beat valid; drives the address stage's LDM/STM select.
REQ-013 base_addr_out  output  ADDR_W  running base for the current beat, fed to the address stage.
REQ-014 func_out  output  3  captured {P,U,W}, held stable for the whole transfer.
REQ-015 load_out  output  1  captured load_in.
REQ-016 reg_idx_out  output  log2(NREG)  register index of the current beat.
REQ-017 last_out  output  1  current beat is the final one.
REQ-018 wb_en_out  output  1  one-cycle base writeback strobe.
REQ-019 wb_data_out  output  ADDR_W  final base value for writeback.
REQ-020 done_out  output  1  one-cycle completion pulse.

Function
REQ-021 The FSM SHALL have three states: IDLE, XFER and DONE.
- IDLE->XFER on start_in when the list is non-zero.
- IDLE->DONE on start_in when the list is zero.
- XFER->DONE on an accepted last beat.
- DONE->IDLE unconditionally.
REQ-022 Latency: start_in sampled at edge N SHALL present the first beat (ctrl_ldm_stm_start_S3_out=1) in cycle N+1.
REQ-023 Beat order SHALL be ascending register index when U=1 and descending when U=0, so the lowest register always maps to the lowest address.
REQ-024 A beat SHALL hold every output stable until mem_ready_in=1. On acceptance, the beat's bit is cleared from the pending list and the next beat is presented in the following cycle.
REQ-025 On each accepted beat, base_addr_out SHALL step by +4 (U=1) or -4 (U=0), modulo 2^ADDR_W (wrap-around, no saturation).
REQ-026 last_out SHALL be high exactly when one pending bit remains.
REQ-027 In DONE, done_out SHALL pulse for one cycle. If W=1 and the list was non-zero, wb_en_out SHALL pulse in the same cycle with wb_data_out = captured base ± 4*popcount(list), sign per U.
REQ-028 An empty list SHALL produce no beats, no writeback, and done_out in cycle N+1.
REQ-029 start_in while busy_out=1 SHALL be ignored, with no effect on captured state.
REQ-030 Outputs SHALL be registered; mem_ready_in SHALL affect only next-state logic, never current outputs combinationally.

Reset
REQ-031 Asserting reset_in SHALL immediately force IDLE and clear the pending list.
REQ-032 On reset, all outputs SHALL be 0, including base_addr_out, func_out and reg_idx_out.
REQ-033 Reset during XFER SHALL abort the transfer with no done_out or wb_en_out pulse.
REQ-034 The first start_in SHALL be honoured on the first edge after reset deasserts.

Structure
REQ-035 State encodings, func bit positions and the step constant 4 SHALL live in the shared package used with mem_addr_calc.
REQ-036 One sub-module, prio_enc, SHALL return the lowest or highest set bit index of the pending list, selected by U.
REQ-037 Popcount SHALL be computed once at capture and held in a register.

Verification
REQ-038 list=16'h0013, base=32'h1000, func=3'b111, ready=1 -> beats r0,r1,r4 with base 1000,1004,1008; last on r4; wb_data=32'h100C.
REQ-039 list=16'h8001, base=32'h2000, func=3'b001 -> beats r15 then r0 with base 2000,1FFC; wb_data=32'h1FF8.
REQ-040 list=16'h0000 -> no beat, done_out in cycle N+1, wb_en_out=0.
REQ-041 ready held low 3 cycles on the second beat -> outputs frozen during the stall; sequence otherwise unchanged; second start_in during busy ignored.
REQ-042 base=32'hFFFFFFFC, U=1, list=16'h0003, W=1 -> base FFFFFFFC then 00000000; wb_data=32'h00000004.
REQ-043 reset_in asserted mid-XFER -> all outputs 0 at once; no done_out; a new start_in after release runs normally.
